mem_mmio_ctrl: RTL

MEM_MMIO_CTRL -- requirements
Module: mem_mmio_ctrl

---
 rtl/mem_mmio_ctrl_pkg.sv | 35 +++
 rtl/uart_tx_fifo.sv | 76 +++++++
 rtl/mem_mmio_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_mmio_ctrl_pkg.sv
// Shared definitions for mem_mmio_ctrl: bus encoding, register offsets,
// STATUS/CTRL bit positions and the address-region type.
`ifndef MEM_MMIO_CTRL_DEFS
`define MEM_MMIO_CTRL_DEFS
`define MEM_WR      1'b1
`define MEM_RD      1'b0
`define REG_TXDATA  2'd0
`define REG_RXDATA  2'd1
`define REG_STATUS  2'd2
`define REG_CTRL    2'd3
`define ST_TX_EMPTY 0
`define ST_TX_FULL  1
`define ST_RX_VALID 2
`define ST_RX_OVR   3
`define ST_TXOVF    4
`define CTRL_EN     0
`endif

package mem_mmio_ctrl_pkg;

    typedef enum logic [1:0] {
        RG_NONE = 2'd0,
        RG_RAM  = 2'd1,
        RG_MMIO = 2'd2
    } region_e;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned REGS_PER_CH = 4;
    localparam int unsigned ST_W        = 5;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Per-channel TX byte FIFO with registered head/empty/full and a
// look-ahead empty flag so the parent can register its valid output.
module uart_tx_fifo
    import mem_mmio_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk_i_w,
    input  logic             rst_i_w,
    input  logic             push_i_w,
    input  logic             pop_i_w,
    input  logic [WIDTH-1:0] wdat_i_w,
    output logic [WIDTH-1:0] head_o_r,
    output logic             empty_o_r,
    output logic             full_o_r,
    output logic             empty_nxt_o_c
);

    localparam int unsigned PW = clog2_min1(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push  = push_i_w & ~full_o_r;
        do_pop   = pop_i_w & ~empty_o_r;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        empty_nxt_o_c = (cnt_d == '0);
        // Next head bypasses storage when the written slot becomes the head.
        head_d = '0;
        if (!empty_nxt_o_c) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdat_i_w : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i_w) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdat_i_w;
        end
    end

    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            head_o_r  <= '0;
            empty_o_r <= 1'b1;
            full_o_r  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            head_o_r  <= head_d;
            empty_o_r <= empty_nxt_o_c;
            full_o_r  <= (cnt_d == CW'(FIFO_DEPTH));
        end
    end

endmodule

// File: rtl/mem_mmio_ctrl.sv
// RAM plus per-channel UART TX/RX register window on a single strobe bus.
// Define JLC3_MMIO_RX_EN to enable the RX holding registers.
module mem_mmio_ctrl
    import mem_mmio_ctrl_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 16,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [AW-1:0] MMIO_BASE = AW'(16'hFE00)
) (
    input  logic                clk_i_w,
    input  logic                rst_i_w,
    input  logic                en_i_w,
    input  logic                wr_i_w,
    input  logic [AW-1:0]       addr_i_w,
    input  logic [DW-1:0]       wdat_i_w,
    output logic [DW-1:0]       rdat_o_r,
    output logic                rvld_o_r,
    output logic [N_CH-1:0]     tx_vld_o_r,
    output logic [8*N_CH-1:0]   tx_dat_o_r,
    input  logic [N_CH-1:0]     tx_rdy_i_w,
    input  logic [N_CH-1:0]     rx_vld_i_w,
    input  logic [8*N_CH-1:0]   rx_dat_i_w,
    output logic                err_o_r
);

    localparam int unsigned MAW = clog2_min1(MEM_DEPTH);
    localparam int unsigned CHW = clog2_min1(N_CH);
    localparam int unsigned WIN = REGS_PER_CH * N_CH;

    logic [DW-1:0]              mem_q [MEM_DEPTH];
    region_e                    region_c;
    logic [AW-1:0]              off_c;
    logic [CHW-1:0]             ch_c;
    logic [1:0]                 reg_c;
    logic [MAW-1:0]             ram_idx_c;
    logic                       acc_rd_c, acc_wr_c;
    logic [DW-1:0]              rd_val_c, rx_word_c;
    logic [N_CH-1:0][ST_W-1:0]  status_c;

    logic [N_CH-1:0] ctrl_en_q, ctrl_en_d, txovf_q, txovf_d;
    logic [N_CH-1:0] rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic [N_CH-1:0] push_c, pop_c;
    logic [N_CH-1:0] fifo_empty, fifo_full, fifo_empty_nxt;

    always_comb begin
        off_c     = addr_i_w - MMIO_BASE;
        ch_c      = CHW'(off_c >> 2);
        reg_c     = off_c[1:0];
        ram_idx_c = addr_i_w[MAW-1:0];
        region_c  = RG_NONE;
        if (32'(addr_i_w) < MEM_DEPTH) begin
            region_c = RG_RAM;
        end else if ((addr_i_w >= MMIO_BASE) && (32'(off_c) < WIN)) begin
            region_c = RG_MMIO;
        end
        acc_rd_c = en_i_w && (wr_i_w == `MEM_RD);
        acc_wr_c = en_i_w && (wr_i_w == `MEM_WR);
    end

    always_comb begin
        status_c = '0;
        for (int c = 0; c < N_CH; c++) begin
            status_c[c][`ST_TX_EMPTY] = fifo_empty[c];
            status_c[c][`ST_TX_FULL]  = fifo_full[c];
            status_c[c][`ST_RX_VALID] = rx_valid_q[c];
            status_c[c][`ST_RX_OVR]   = rx_ovr_q[c];
            status_c[c][`ST_TXOVF]    = txovf_q[c];
        end
    end

`ifdef JLC3_MMIO_RX_EN
    logic [N_CH-1:0][7:0] rx_data_q, rx_data_d;
    logic [N_CH-1:0]      rx_rd_c;
    assign rx_word_c = DW'(rx_data_q[ch_c]);
`else
    logic unused_rx;
    assign unused_rx = ^{rx_vld_i_w, rx_dat_i_w};
    assign rx_word_c = '0;
`endif

    always_comb begin
        rd_val_c = '0;
        case (region_c)
            RG_RAM: rd_val_c = mem_q[ram_idx_c];
            RG_MMIO: begin
                case (reg_c)
                    `REG_RXDATA: rd_val_c = rx_word_c;
                    `REG_STATUS: rd_val_c = DW'(status_c[ch_c]);
                    `REG_CTRL:   rd_val_c[`CTRL_EN] = ctrl_en_q[ch_c];
                    default:     rd_val_c = '0;
                endcase
            end
            default: rd_val_c = '0;
        endcase
    end

    // Register side effects; a full FIFO is judged at cycle start, before any pop.
    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        txovf_d    = txovf_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        push_c     = '0;
        pop_c      = tx_vld_o_r & tx_rdy_i_w;
`ifdef JLC3_MMIO_RX_EN
        rx_data_d  = rx_data_q;
        rx_rd_c    = '0;
`endif
        for (int c = 0; c < N_CH; c++) begin
            if ((region_c == RG_MMIO) && (ch_c == CHW'(c))) begin
                if (acc_wr_c && (reg_c == `REG_TXDATA)) begin
                    if (fifo_full[c]) begin
                        txovf_d[c] = 1'b1;
                    end else begin
                        push_c[c] = 1'b1;
                    end
                end
                if (acc_wr_c && (reg_c == `REG_CTRL)) begin
                    ctrl_en_d[c] = wdat_i_w[`CTRL_EN];
                end
                if (acc_rd_c && (reg_c == `REG_STATUS)) begin
                    txovf_d[c]  = 1'b0;
                    rx_ovr_d[c] = 1'b0;
                end
`ifdef JLC3_MMIO_RX_EN
                rx_rd_c[c] = acc_rd_c && (reg_c == `REG_RXDATA);
`endif
            end
`ifdef JLC3_MMIO_RX_EN
            // A byte arriving while RXDATA is read replaces a consumed byte, not an unread one.
            if (rx_vld_i_w[c]) begin
                rx_data_d[c] = rx_dat_i_w[8*c +: 8];
                if (rx_valid_q[c] && !rx_rd_c[c]) begin
                    rx_ovr_d[c] = 1'b1;
                end
                rx_valid_d[c] = 1'b1;
            end else if (rx_rd_c[c]) begin
                rx_valid_d[c] = 1'b0;
            end
`endif
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        uart_tx_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .WIDTH      (BYTE_W)
        ) u_fifo (
            .clk_i_w       (clk_i_w),
            .rst_i_w       (rst_i_w),
            .push_i_w      (push_c[g]),
            .pop_i_w       (pop_c[g]),
            .wdat_i_w      (wdat_i_w[BYTE_W-1:0]),
            .head_o_r      (tx_dat_o_r[8*g +: 8]),
            .empty_o_r     (fifo_empty[g]),
            .full_o_r      (fifo_full[g]),
            .empty_nxt_o_c (fifo_empty_nxt[g])
        );
    end

    always_ff @(posedge clk_i_w) begin
        if (!rst_i_w && acc_wr_c && (region_c == RG_RAM)) begin
            mem_q[ram_idx_c] <= wdat_i_w;
        end
    end

    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            rdat_o_r   <= '0;
            rvld_o_r   <= 1'b0;
            err_o_r    <= 1'b0;
            tx_vld_o_r <= '0;
            ctrl_en_q  <= '0;
            txovf_q    <= '0;
            rx_valid_q <= '0;
            rx_ovr_q   <= '0;
        end else begin
            rvld_o_r <= acc_rd_c;
            if (acc_rd_c) begin
                rdat_o_r <= rd_val_c;
            end
            err_o_r    <= en_i_w && (region_c == RG_NONE);
            tx_vld_o_r <= ctrl_en_d & ~fifo_empty_nxt;
            ctrl_en_q  <= ctrl_en_d;
            txovf_q    <= txovf_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

`ifdef JLC3_MMIO_RX_EN
    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            rx_data_q <= '0;
        end else begin
            rx_data_q <= rx_data_d;
        end
    end
`endif

endmodule
